cgra_config_loader: RTL and testbench
=====================================

// Module: cgra_config_loader
// PURPOSE
//   Synthesizable config sequencer directly upstream of the CGRA top config port.
//   Takes a stream of (addr, data) config words from a host/ROM source via
//   valid/ready, buffers them in a small FIFO, and issues one config write per
//   cycle on config_addr_out/config_data_out, honouring a stall from the array.
//   Flags completion and parks the address bus at 0 once the last word is written.
// PARAMETERS
//   ADDR_W      32  config address width
//   DATA_W      32  config data width
//   FIFO_DEPTH  4   input buffer entries (power of 2, >=2)
//   COUNT_W     16  width of written-word counter
// PORTS
//   clk_in            in   1       clock
//   reset_in          in   1       asynchronous reset, active-low
//   start_in          in   1       1-cycle pulse: begin a load (IDLE/DONE only)
//   word_valid_in     in   1       source word valid
//   word_ready_out    out  1       loader can accept word this cycle
//   word_addr_in      in   ADDR_W  config address of source word
//   word_data_in      in   DATA_W  config data of source word
//   word_last_in      in   1       marks final word of the bitstream
//   config_stall_in   in   1       array cannot take a write this cycle
//   config_valid_out  out  1       config write strobe
//   config_addr_out   out  ADDR_W  config address to array
//   config_data_out   out  DATA_W  config data to array
//   config_done_out   out  1       load complete (level, held in DONE)
//   config_count_out  out  COUNT_W writes accepted by array this load (saturating)
// BEHAVIOUR
//   Reset (reset_in=0, async): state IDLE, FIFO emptied, all outputs 0.
//   Handshake: word accepted on edge where word_valid_in && word_ready_out.
//     Array beat accepted on edge where config_valid_out && !config_stall_in.
//   word_ready_out = (state==LOAD) && !fifo_full; independent of same-cycle pop.
//   Output register: loads FIFO head when empty or its beat is accepted; holds
//     addr/data/valid unchanged while config_stall_in=1.
//   Latency: word accepted in cycle t -> config_valid_out in cycle t+2 (empty
//     pipe, no stall); back-to-back words give one write per cycle.
//   States:
//     IDLE : ready=0, outputs 0. start_in -> LOAD (FIFO, count cleared).
//     LOAD : accept words; on accepting word with word_last_in=1 -> DRAIN.
//     DRAIN: ready=0; when FIFO empty and no pending output beat -> DONE.
//     DONE : config_done_out=1, config_addr_out=0, config_data_out=0,
//            config_valid_out=0; start_in -> LOAD, clears done and count.
//   config_done_out rises the cycle after the last beat is accepted by array.
//   start_in in LOAD/DRAIN ignored. Single-word load (last on first word) valid.
//   Order preserved exactly; no word dropped or duplicated under any stall.
//   FIFO full: ready=0 until a pop frees a slot (ready returns next cycle).
//   Counter increments per accepted beat; saturates at 2^COUNT_W-1.
//   Reset mid-LOAD/DRAIN: immediate return to IDLE, pending words discarded,
//     outputs 0; no partial write is emitted after reset release.
// TESTING
//   1 Reset: assert reset_in=0 between edges -> all outputs 0 immediately, ready=0.
//   2 start, 3 words (0x10/0xA,0x14/0xB,0x18/0xC,last on 3rd), no stall -> writes
//     at t+2..t+4 in order, done=1 next cycle with addr_out=0, count=3.
//   3 Stall held 8 cycles while feeding 6 words (DEPTH=4) -> ready drops after
//     4 buffered + 1 in output reg, all 6 written in order after stall, count=6.
//   4 Stall toggling every cycle on 5 words -> addr/data stable while stalled,
//     exactly 5 strobes accepted, no duplicates.
//   5 reset_in low mid-LOAD after 2 of 5 words -> IDLE, valid=0 at once; new start
//     + 1 word with last -> single write, done=1, count=1.
//   6 start_in pulsed during LOAD ignored; start_in in DONE -> done=0, count=0,
//     ready=1 next cycle.

Source files
------------

// File: rtl/cgra_config_loader.sv
// cgra_config_loader: buffers (addr, data) config words in a small FIFO and
// issues one stall-aware config write per cycle to the CGRA config port.
`default_nettype none

module cgra_config_loader #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int COUNT_W    = 16
) (
    input  logic               clk_in,
    input  logic               reset_in,
    input  logic               start_in,
    input  logic               word_valid_in,
    output logic               word_ready_out,
    input  logic [ADDR_W-1:0]  word_addr_in,
    input  logic [DATA_W-1:0]  word_data_in,
    input  logic               word_last_in,
    input  logic               config_stall_in,
    output logic               config_valid_out,
    output logic [ADDR_W-1:0]  config_addr_out,
    output logic [DATA_W-1:0]  config_data_out,
    output logic               config_done_out,
    output logic [COUNT_W-1:0] config_count_out
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state, state_next;

    logic [ADDR_W-1:0]  fifo_addr [FIFO_DEPTH];
    logic [DATA_W-1:0]  fifo_data [FIFO_DEPTH];
    logic [PTR_W:0]     wr_ptr, rd_ptr;
    logic               fifo_empty, fifo_full;
    logic               push, pop, slot_free, beat_accept, start_load;

    logic               out_valid;
    logic [ADDR_W-1:0]  out_addr;
    logic [DATA_W-1:0]  out_data;
    logic [COUNT_W-1:0] count;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign fifo_empty  = (wr_ptr == rd_ptr);
    assign fifo_full   = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                         (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

    assign word_ready_out = (state == LOAD) && !fifo_full;
    assign push        = word_valid_in && word_ready_out;
    assign beat_accept = out_valid && !config_stall_in;
    assign slot_free   = !out_valid || !config_stall_in;
    assign pop         = slot_free && !fifo_empty;
    assign start_load  = start_in && ((state == IDLE) || (state == DONE));

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_in) state_next = LOAD;
            LOAD:    if (push && word_last_in) state_next = DRAIN;
            // Output slot frees this cycle and nothing is left behind it.
            DRAIN:   if (fifo_empty && slot_free) state_next = DONE;
            DONE:    if (start_in) state_next = LOAD;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (start_load) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (PTR_W+1)'(1);
        end
    end

    always_ff @(posedge clk_in) begin
        if (push) begin
            fifo_addr[wr_ptr[PTR_W-1:0]] <= word_addr_in;
            fifo_data[wr_ptr[PTR_W-1:0]] <= word_data_in;
        end
    end

    // Output register: refills whenever its slot frees; parks at zero when
    // there is nothing to send so the bus reads 0 in IDLE/DONE.
    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            out_valid <= 1'b0;
            out_addr  <= '0;
            out_data  <= '0;
        end else if (slot_free) begin
            if (!fifo_empty) begin
                out_valid <= 1'b1;
                out_addr  <= fifo_addr[rd_ptr[PTR_W-1:0]];
                out_data  <= fifo_data[rd_ptr[PTR_W-1:0]];
            end else begin
                out_valid <= 1'b0;
                out_addr  <= '0;
                out_data  <= '0;
            end
        end
    end

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            count <= '0;
        end else if (start_load) begin
            count <= '0;
        end else if (beat_accept && (count != {COUNT_W{1'b1}})) begin
            count <= count + COUNT_W'(1);
        end
    end

    assign config_valid_out = out_valid;
    assign config_addr_out  = out_addr;
    assign config_data_out  = out_data;
    assign config_done_out  = (state == DONE);
    assign config_count_out = count;

endmodule

`default_nettype wire

// File: tb/tb_cgra_config_loader.sv
// Bench for cgra_config_loader: directed load scenarios with a queue-based
// scoreboard of accepted words checked against every accepted array beat.
`default_nettype none

module tb_cgra_config_loader;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
        logic        l;
    } word_t;

    logic        clk_in = 1'b0;
    logic        reset_in;
    logic        start_in;
    logic        word_valid_in;
    logic        word_ready_out;
    logic [31:0] word_addr_in;
    logic [31:0] word_data_in;
    logic        word_last_in;
    logic        config_stall_in;
    logic        config_valid_out;
    logic [31:0] config_addr_out;
    logic [31:0] config_data_out;
    logic        config_done_out;
    logic [15:0] config_count_out;

    cgra_config_loader dut (
        .clk_in           (clk_in),
        .reset_in         (reset_in),
        .start_in         (start_in),
        .word_valid_in    (word_valid_in),
        .word_ready_out   (word_ready_out),
        .word_addr_in     (word_addr_in),
        .word_data_in     (word_data_in),
        .word_last_in     (word_last_in),
        .config_stall_in  (config_stall_in),
        .config_valid_out (config_valid_out),
        .config_addr_out  (config_addr_out),
        .config_data_out  (config_data_out),
        .config_done_out  (config_done_out),
        .config_count_out (config_count_out)
    );

    always #5 clk_in = ~clk_in;

    int    checks = 0;
    int    errors = 0;
    int    acc_count = 0;
    bit    armed = 0;
    bit    src_fire = 0;
    bit    prev_hold = 0;
    bit    gaps = 0;
    int    stall_mode = 0;
    logic [31:0] prev_addr, prev_data;
    word_t exp_q[$];
    word_t src_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Source: offers the head of src_q, holds it until accepted.
    always @(posedge clk_in) begin
        #2;
        if (src_fire && src_q.size() > 0) void'(src_q.pop_front());
        if (word_valid_in && !src_fire) begin
            word_valid_in = 1'b1;
        end else if (src_q.size() > 0 && (!gaps || $urandom_range(0, 2) != 0)) begin
            word_valid_in = 1'b1;
            word_addr_in  = src_q[0].a;
            word_data_in  = src_q[0].d;
            word_last_in  = src_q[0].l;
        end else begin
            word_valid_in = 1'b0;
            word_last_in  = 1'b0;
        end
        if (stall_mode == 1) config_stall_in = ~config_stall_in;
        else if (stall_mode == 2) config_stall_in = $urandom_range(0, 1) != 0;
    end

    // Scoreboard: accepted words go in, accepted array beats must come out in order.
    always @(negedge clk_in) begin
        if (!reset_in) begin
            exp_q.delete();
            acc_count = 0;
            prev_hold = 0;
            src_fire  = 0;
        end else if (armed) begin
            if (prev_hold) begin
                chk("hold_valid", config_valid_out, 1);
                chk("hold_addr", config_addr_out, prev_addr);
                chk("hold_data", config_data_out, prev_data);
            end
            if (config_valid_out && !config_stall_in) begin
                chk("beat_was_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    chk("beat_addr", config_addr_out, exp_q[0].a);
                    chk("beat_data", config_data_out, exp_q[0].d);
                    void'(exp_q.pop_front());
                end
            end
            prev_hold = config_valid_out && config_stall_in;
            prev_addr = config_addr_out;
            prev_data = config_data_out;
            src_fire  = word_valid_in && word_ready_out;
            if (src_fire) begin
                exp_q.push_back('{word_addr_in, word_data_in, word_last_in});
                acc_count++;
            end
        end
    end

    task automatic pulse_start();
        @(posedge clk_in); #1;
        start_in = 1'b1;
        acc_count = 0;
        @(posedge clk_in); #1;
        start_in = 1'b0;
    endtask

    task automatic push_random(input int n);
        for (int i = 0; i < n; i++)
            src_q.push_back('{$urandom & 32'hFFFF_FFFC, $urandom, (i == n - 1)});
    endtask

    task automatic wait_done(input int exp_cnt);
        int n = 0;
        while (!config_done_out && n < 500) begin
            @(negedge clk_in);
            n++;
        end
        chk("done_reached", config_done_out, 1);
        chk("done_valid", config_valid_out, 0);
        chk("done_addr", config_addr_out, 0);
        chk("done_data", config_data_out, 0);
        chk("done_count", config_count_out, exp_cnt);
        chk("all_written", exp_q.size(), 0);
        chk("all_sent", src_q.size(), 0);
    endtask

    initial begin
        reset_in = 1'b1; start_in = 1'b0; config_stall_in = 1'b0;
        word_valid_in = 1'b0; word_addr_in = '0; word_data_in = '0; word_last_in = 1'b0;

        // Reset asserted between edges: outputs must clear without a clock.
        repeat (2) @(posedge clk_in);
        #3 reset_in = 1'b0;
        #1;
        chk("rst_valid", config_valid_out, 0);
        chk("rst_ready", word_ready_out, 0);
        chk("rst_addr", config_addr_out, 0);
        chk("rst_data", config_data_out, 0);
        chk("rst_done", config_done_out, 0);
        chk("rst_count", config_count_out, 0);
        repeat (2) @(posedge clk_in);
        #3 reset_in = 1'b1;
        armed = 1;

        // Three words, no stall: exact latency and done timing.
        pulse_start();
        src_q.push_back('{32'h10, 32'hA, 1'b0});
        src_q.push_back('{32'h14, 32'hB, 1'b0});
        src_q.push_back('{32'h18, 32'hC, 1'b1});
        @(negedge clk_in);
        chk("t0_ready", word_ready_out, 1);
        chk("t0_valid", config_valid_out, 0);
        @(negedge clk_in);
        chk("t1_valid", config_valid_out, 0);
        @(negedge clk_in);
        chk("t2_valid", config_valid_out, 1);
        chk("t2_addr", config_addr_out, 32'h10);
        chk("t2_data", config_data_out, 32'hA);
        @(negedge clk_in);
        chk("t3_addr", config_addr_out, 32'h14);
        chk("t3_data", config_data_out, 32'hB);
        chk("t3_ready_drain", word_ready_out, 0);
        @(negedge clk_in);
        chk("t4_addr", config_addr_out, 32'h18);
        chk("t4_data", config_data_out, 32'hC);
        chk("t4_done", config_done_out, 0);
        @(negedge clk_in);
        chk("t5_done", config_done_out, 1);
        wait_done(3);

        // Stall held while six words arrive: only FIFO + output reg can fill.
        @(posedge clk_in); #1 config_stall_in = 1'b1;
        pulse_start();
        push_random(6);
        repeat (7) @(posedge clk_in);
        @(negedge clk_in);
        chk("stall_accepted", acc_count, 5);
        chk("stall_ready", word_ready_out, 0);
        chk("stall_valid", config_valid_out, 1);
        @(posedge clk_in); #1 config_stall_in = 1'b0;
        wait_done(6);

        // Stall toggling every cycle.
        stall_mode = 1;
        pulse_start();
        push_random(5);
        wait_done(5);
        @(posedge clk_in); #1 stall_mode = 0; config_stall_in = 1'b0;

        // Random stall and source gaps over a longer stream.
        stall_mode = 2; gaps = 1;
        pulse_start();
        push_random(20);
        wait_done(20);
        @(posedge clk_in); #1 stall_mode = 0; config_stall_in = 1'b0; gaps = 0;

        // Reset in the middle of a load, then a single-word load.
        pulse_start();
        push_random(5);
        for (int n = 0; n < 50 && acc_count < 2; n++) @(negedge clk_in);
        chk("mid_two_accepted", acc_count >= 2, 1);
        @(posedge clk_in);
        #3 reset_in = 1'b0;
        src_q.delete();
        word_valid_in = 1'b0;
        #1;
        chk("midrst_valid", config_valid_out, 0);
        chk("midrst_ready", word_ready_out, 0);
        chk("midrst_addr", config_addr_out, 0);
        chk("midrst_count", config_count_out, 0);
        repeat (2) @(posedge clk_in);
        #3 reset_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_in);
            chk("postrst_no_write", config_valid_out, 0);
            chk("postrst_idle_done", config_done_out, 0);
        end
        pulse_start();
        src_q.push_back('{32'h40, 32'h55, 1'b1});
        wait_done(1);

        // start ignored during LOAD; start in DONE clears done and count.
        pulse_start();
        src_q.push_back('{32'h80, 32'h1, 1'b0});
        src_q.push_back('{32'h84, 32'h2, 1'b0});
        src_q.push_back('{32'h88, 32'h3, 1'b0});
        @(posedge clk_in); #1 start_in = 1'b1;
        @(posedge clk_in); #1 start_in = 1'b0;
        src_q.push_back('{32'h8C, 32'h4, 1'b1});
        wait_done(4);
        @(posedge clk_in); #1 start_in = 1'b1;
        @(posedge clk_in); #1 start_in = 1'b0;
        @(negedge clk_in);
        chk("restart_done", config_done_out, 0);
        chk("restart_count", config_count_out, 0);
        chk("restart_ready", word_ready_out, 1);
        src_q.push_back('{32'h90, 32'h5, 1'b1});
        wait_done(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
